// File: rtl/between_fifo_out_pkg.sv
// Shared constants and types for the between_fifo_out UART byte path:
// CRC-8 parameters, egress FSM states and error flag bit positions.
package between_fifo_out_pkg;

    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;

    localparam int ERR_PARITY   = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_OVERRUN  = 2;
    localparam int ERR_PROTOCOL = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_START,
        S_WAIT
    } egress_state_t;

    // CRC-8, MSB first, unreflected: all eight bit steps unrolled into one cycle.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] r;
        // NOTE: blocking '=' is right here: each loop step must see the previous step's result.
        r = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/between_fifo_out_sync_fifo.sv
// Single-clock circular FIFO with occupancy count and registered read data.
module sync_fifo #(
    parameter  int DEPTH = 512,
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-2:0]    wr_ptr;
    logic [CW-2:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign wr_ok = we & ~full;
    assign rd_ok = re & ~empty;

    // NOTE: storage and its read register carry no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wdata;
        if (rd_ok) rdata <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/between_fifo_out.sv
// UART sender byte path: synchronized switch capture, CRC/error tracking, FIFO, egress handshake.
// Define BETWEEN_FIFO_CRC_EN to build the CRC-8 logic; otherwise crc is tied to 0x00.
module between_fifo_out
    import between_fifo_out_pkg::*;
#(
    parameter  int DEPTH = 512,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [7:0]    t,
    input  logic          tsent,
    output logic          trecieve,
    output logic [7:0]    crc,
    output logic [3:0]    error,
    output logic [CW-1:0] fifo_count,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic [7:0]    out_data,
    output logic          out_start,
    input  logic          out_finish,
    output logic          is_finish
);

    logic [1:0]    tsent_sync;
    logic          tsent_prev;
    logic [7:0]    t_s1;
    logic [7:0]    t_s2;
    logic [7:0]    hold;
    logic          pending;
    logic          press;
    logic          wr_en;
    logic          rd_en;
    logic [7:0]    rd_data;
    egress_state_t state;

    assign press     = tsent_sync[1] & ~tsent_prev & enable;
    assign wr_en     = pending & ~fifo_full;
    assign rd_en     = (state == S_READ);
    assign is_finish = (state == S_IDLE) && fifo_empty;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .wdata (hold),
        .re    (rd_en),
        .rdata (rd_data),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // NOTE: sequential state uses '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tsent_sync <= '0;
            tsent_prev <= 1'b0;
            t_s1       <= '0;
            t_s2       <= '0;
            hold       <= '0;
            pending    <= 1'b0;
            trecieve   <= 1'b0;
            error      <= '0;
        end else begin
            tsent_sync <= {tsent_sync[0], tsent};
            tsent_prev <= tsent_sync[1];
            t_s1       <= t;
            t_s2       <= t_s1;
            trecieve   <= wr_en;
            if (wr_en && ^hold)          error[ERR_PARITY]   <= 1'b1;
            if (pending && fifo_full)    error[ERR_OVERFLOW] <= 1'b1;
            if (press && pending)        error[ERR_OVERRUN]  <= 1'b1;
            if (out_finish && state != S_WAIT) error[ERR_PROTOCOL] <= 1'b1;
            // A press landing on the pending write is flagged and dropped; the held byte is kept.
            if (press && !pending) hold <= t_s2;
            pending <= press && !pending;
        end
    end

`ifdef BETWEEN_FIFO_CRC_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     crc <= CRC_INIT;
        else if (wr_en) crc <= crc8_next(crc, hold);
    end
`else
    assign crc = 8'h00;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            out_data  <= '0;
            out_start <= 1'b0;
        end else begin
            out_start <= 1'b0;
            case (state)
                S_IDLE:  if (enable && !fifo_empty) state <= S_READ;
                S_READ:  state <= S_LOAD;
                S_LOAD: begin
                    out_data  <= rd_data;
                    out_start <= 1'b1;
                    state     <= S_START;
                end
                S_START: state <= S_WAIT;
                S_WAIT:  if (out_finish) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_between_fifo_out.sv
// Scoreboard bench for between_fifo_out: expected egress bytes are queued at stimulus time
// and a negedge monitor pops and compares them on every out_start.
module tb_between_fifo_out;

    localparam int DEPTH = 512;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef BETWEEN_FIFO_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b1;
    logic [7:0]    t = 8'h00;
    logic          tsent = 1'b0;
    logic          trecieve;
    logic [7:0]    crc;
    logic [3:0]    error;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    out_data;
    logic          out_start;
    logic          out_finish = 1'b0;
    logic          is_finish;

    int checks = 0;
    int errors = 0;
    int trecv_cnt = 0;
    int ostart_cnt = 0;
    logic [7:0] exp_q[$];

    between_fifo_out #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .t          (t),
        .tsent      (tsent),
        .trecieve   (trecieve),
        .crc        (crc),
        .error      (error),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .out_data   (out_data),
        .out_start  (out_start),
        .out_finish (out_finish),
        .is_finish  (is_finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every out_start must match the oldest queued byte.
    always @(negedge clk) begin
        if (trecieve) trecv_cnt++;
        if (out_start) begin
            ostart_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_start_unexpected: got data 0x%0h expected no out_start", out_data);
            end else begin
                check("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] v);
        t = v;
        @(posedge clk);
        #1 tsent = 1'b1;
        repeat (3) @(posedge clk);
        #1 tsent = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_finish();
        out_finish = 1'b1;
        @(posedge clk);
        #1 out_finish = 1'b0;
    endtask

    task automatic send(input logic [7:0] v);
        exp_q.push_back(v);
        press(v);
        repeat (3) @(posedge clk);
        #1;
        pulse_finish();
    endtask

    initial begin
        int rx_k;
        int st_k;
        logic [CW-1:0] cnt_at_rx;
        logic [7:0] crc_at_rx;
        logic [3:0] err_at_rx;
        int trecv_base;
        int ostart_base;

        do_reset();
        @(negedge clk);
        check("reset_trecieve", {31'h0, trecieve}, 32'h0);
        check("reset_crc", {24'h0, crc}, 32'h0);
        check("reset_error", {28'h0, error}, 32'h0);
        check("reset_count", {22'h0, fifo_count}, 32'h0);
        check("reset_empty", {31'h0, fifo_empty}, 32'h1);
        check("reset_full", {31'h0, fifo_full}, 32'h0);
        check("reset_out_data", {24'h0, out_data}, 32'h0);
        check("reset_out_start", {31'h0, out_start}, 32'h0);
        check("reset_is_finish", {31'h0, is_finish}, 32'h1);

        // Single byte 0x31: ingress latency, CRC, parity flag, egress latency.
        t = 8'h31;
        exp_q.push_back(8'h31);
        @(negedge clk);
        tsent = 1'b1;
        rx_k = -1;
        st_k = -1;
        cnt_at_rx = '0;
        crc_at_rx = '0;
        err_at_rx = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (trecieve && rx_k < 0) begin
                rx_k = k;
                cnt_at_rx = fifo_count;
                crc_at_rx = crc;
                err_at_rx = error;
            end
            if (out_start && st_k < 0) st_k = k;
            if (k == 3) tsent = 1'b0;
        end
        check("trecieve_latency", rx_k, 3);
        check("count_after_write", {22'h0, cnt_at_rx}, 32'h1);
        check("crc_0x31", {24'h0, crc_at_rx}, CRC_ON ? 32'h97 : 32'h0);
        check("error_0x31_parity", {28'h0, err_at_rx}, 32'h1);
        check("out_start_latency", st_k, 6);

        // 0x32 while the serializer holds off: no second out_start until out_finish.
        @(posedge clk);
        #1;
        exp_q.push_back(8'h32);
        press(8'h32);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("stalled_out_starts", ostart_cnt, 1);
        check("stalled_count", {22'h0, fifo_count}, 32'h1);
        check("crc_0x31_0x32", {24'h0, crc}, CRC_ON ? 32'h72 : 32'h0);
        @(posedge clk);
        #1;
        pulse_finish();
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("released_out_starts", ostart_cnt, 2);
        check("queue_drained_1", exp_q.size(), 0);
        @(posedge clk);
        #1;
        pulse_finish();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("is_finish_after_drain", {31'h0, is_finish}, 32'h1);

        // out_finish outside WAIT is a protocol error.
        @(posedge clk);
        #1;
        pulse_finish();
        @(negedge clk);
        check("error_protocol", {28'h0, error}, 32'h9);

        // Parity flag: clear on even byte, set on 0x07, sticky afterwards.
        do_reset();
        send(8'h03);
        @(negedge clk);
        check("error_even_byte", {28'h0, error}, 32'h0);
        @(posedge clk);
        #1;
        send(8'h07);
        @(negedge clk);
        check("error_0x07", {28'h0, error}, 32'h1);
        @(posedge clk);
        #1;
        send(8'h03);
        @(negedge clk);
        check("error_sticky", {28'h0, error}, 32'h1);
        check("queue_drained_2", exp_q.size(), 0);

        // enable low: press ignored.
        @(posedge clk);
        #1;
        enable = 1'b0;
        trecv_base = trecv_cnt;
        press(8'h55);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("disabled_trecieve", trecv_cnt - trecv_base, 0);
        check("disabled_count", {22'h0, fifo_count}, 32'h0);
        @(posedge clk);
        #1 enable = 1'b1;

        // Reset asserted while waiting on the serializer.
        do_reset();
        exp_q.push_back(8'hAA);
        press(8'hAA);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("aa_delivered", exp_q.size(), 0);
        #2 reset = 1'b0;
        #1;
        check("midreset_out_data", {24'h0, out_data}, 32'h0);
        check("midreset_is_finish", {31'h0, is_finish}, 32'h1);
        check("midreset_count", {22'h0, fifo_count}, 32'h0);
        check("midreset_error", {28'h0, error}, 32'h0);
        check("midreset_crc", {24'h0, crc}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        ostart_base = ostart_cnt;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("no_start_after_reset", ostart_cnt - ostart_base, 0);

        // Fill: first byte leaves, next 512 fill the FIFO, one more is dropped.
        @(posedge clk);
        #1;
        trecv_base = trecv_cnt;
        ostart_base = ostart_cnt;
        for (int i = 0; i < DEPTH + 1; i++) begin
            exp_q.push_back(i[7:0]);
            press(i[7:0]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("fill_trecieve", trecv_cnt - trecv_base, DEPTH + 1);
        check("fill_full", {31'h0, fifo_full}, 32'h1);
        check("fill_count", {22'h0, fifo_count}, DEPTH);
        @(posedge clk);
        #1;
        press(8'h01);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("overflow_trecieve", trecv_cnt - trecv_base, DEPTH + 1);
        check("overflow_count", {22'h0, fifo_count}, DEPTH);
        check("overflow_error", {28'h0, error}, 32'h3);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            pulse_finish();
            repeat (5) @(posedge clk);
            #1;
        end
        pulse_finish();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drain_out_starts", ostart_cnt - ostart_base, DEPTH + 1);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_is_finish", {31'h0, is_finish}, 32'h1);
        check("drain_error", {28'h0, error}, 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
